sysid_boot_checker: RTL

- Avalon-MM read sequencer placed in front of the system-ID slave.
- After reset, or on request, it reads the ID word (address 0) and then the timestamp word (address 1).
- It compares both words against the expected build values and holds the captured words and pass/fail flags.
- Boot firmware and the status LED logic use these results to detect a mismatched FPGA image.

---
 rtl/sysid_boot_checker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// Module      : sysid_boot_checker
// Description : Avalon-MM read sequencer for the system-ID slave. Reads the
//               ID word (address 0) and the build timestamp (address 1)
//               after reset or on request, compares both against the expected
//               build values and holds the captured words plus pass/fail
//               flags and a saturating mismatch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1344603788,
    parameter int unsigned READ_LATENCY       = 0,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [7:0]  err_count
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd_id   = 3'd1;
    localparam logic [2:0] c_st_wait_id = 3'd2;
    localparam logic [2:0] c_st_rd_ts   = 3'd3;
    localparam logic [2:0] c_st_wait_ts = 3'd4;
    localparam logic [2:0] c_st_finish  = 3'd5;

    // Latency fits in three bits (legal range 0..7).
    localparam logic [2:0] c_lat = 3'(READ_LATENCY);

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        auto_q, auto_d;
    logic        valid_q, valid_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic [7:0]  err_q, err_d;
    logic        w_mismatch;

    // Next-state and datapath: sequence the two reads, capture on the data edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        auto_d     = auto_q;
        valid_d    = valid_q;
        id_d       = id_q;
        ts_d       = ts_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        err_d      = err_q;
        w_mismatch = (id_q != EXPECTED_ID) || (ts_q != EXPECTED_TIMESTAMP);

        case (state_q)
            c_st_idle: begin
                // start and the pending auto-start are both honoured only here,
                // so requests during a check are dropped rather than queued.
                if (start || auto_q) begin
                    state_d = c_st_rd_id;
                    valid_d = 1'b0;
                    auto_d  = 1'b0;
                end
            end
            c_st_rd_id: begin
                cnt_d = c_lat;
                if (c_lat == 3'd0) begin
                    id_d    = sysid_readdata;
                    state_d = c_st_rd_ts;
                end else begin
                    state_d = c_st_wait_id;
                end
            end
            c_st_wait_id: begin
                cnt_d = cnt_q - 3'd1;
                // cnt==1 is the last latency cycle; <= guards a corrupted zero.
                if (cnt_q <= 3'd1) begin
                    id_d    = sysid_readdata;
                    state_d = c_st_rd_ts;
                end
            end
            c_st_rd_ts: begin
                cnt_d = c_lat;
                if (c_lat == 3'd0) begin
                    ts_d    = sysid_readdata;
                    state_d = c_st_finish;
                end else begin
                    state_d = c_st_wait_ts;
                end
            end
            c_st_wait_ts: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    ts_d    = sysid_readdata;
                    state_d = c_st_finish;
                end
            end
            c_st_finish: begin
                id_ok_d = (id_q == EXPECTED_ID);
                ts_ok_d = (ts_q == EXPECTED_TIMESTAMP);
                valid_d = 1'b1;
                if (w_mismatch && (err_q != 8'hFF)) begin
                    err_d = err_q + 8'd1;
                end
                state_d = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // State and result registers; reset aborts any check in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_st_idle;
            cnt_q   <= 3'd0;
            auto_q  <= AUTO_START;
            valid_q <= 1'b0;
            id_q    <= 32'd0;
            ts_q    <= 32'd0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            id_ok_q <= id_ok_d;
            ts_ok_q <= ts_ok_d;
            err_q   <= err_d;
        end
    end

    // Bus and status outputs decoded from the current state.
    always_comb begin
        sysid_read    = (state_q == c_st_rd_id) || (state_q == c_st_rd_ts);
        sysid_address = (state_q == c_st_rd_ts) || (state_q == c_st_wait_ts);
        busy          = (state_q != c_st_idle);
        done          = (state_q == c_st_finish);
    end

    assign valid           = valid_q;
    assign id_value        = id_q;
    assign timestamp_value = ts_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign err_count       = err_q;

endmodule
`default_nettype wire
